// File: rtl/paged_mem_pkg.sv
// Shared types and width helpers for the paged memory reader: FSM encoding
// and the field widths that make up a queued job record {page, nent, bx}.
package paged_mem_pkg;

   localparam int BX_W = 2;

   // Index width that never collapses to zero for one- or two-entry ranges.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_READ    = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_RELEASE = 3'd4
   } pmr_state_e;

endpackage

// File: rtl/pmr_skid_fifo.sv
// Small register FIFO that catches port-B return data so nothing is lost
// while the downstream stalls; count feeds the reader's credit check.
module pmr_skid_fifo
   import paged_mem_pkg::*;
#(
   parameter int W     = 33,
   parameter int DEPTH = 3,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = clog2_min1(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   // The writer is credit-limited, so a push never meets a full FIFO; the
   // guard only keeps the pointers sane if that contract is ever broken.
   always_comb begin
      push  = in_valid && (cnt_q != CW'(DEPTH));
      pop   = (cnt_q != '0) && out_ready;
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q] = in_data;
         wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      end
      if (pop) begin
         rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = mem_q[rd_q];
   assign count     = cnt_q;

endmodule

// File: rtl/paged_mem_reader.sv
// Drains completed BRAM pages, announced by the writer, onto a valid/ready
// stream and hands each page back with a one-cycle release pulse.
module paged_mem_reader
   import paged_mem_pkg::*;
#(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 16,
   parameter int PAGES     = 2,
   parameter int NENT_W    = 6,
   parameter int READ_LAT  = 2,
   localparam int ADDR_W   = clog2_min1(RAM_DEPTH),
   localparam int PAGE_W   = clog2_min1(PAGES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 page_done,
   input  logic [PAGE_W-1:0]    page_in,
   input  logic [NENT_W-1:0]    nent_in,
   input  logic [BX_W-1:0]      bx_in,
   output logic                 mem_enb,
   output logic [PAGE_W-1:0]    mem_pageb,
   output logic [ADDR_W-1:0]    mem_addrb,
   input  logic [RAM_WIDTH-1:0] mem_doutb,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RAM_WIDTH-1:0] out_data,
   output logic [BX_W-1:0]      out_bx,
   output logic                 out_last,
   output logic                 page_release,
   output logic [PAGE_W-1:0]    release_pg,
   output logic                 busy,
   output logic                 err_ovf,
   output logic                 err_nent,
   output pmr_state_e           dbg_state
);

   localparam int SKID_D  = READ_LAT + 1;
   localparam int SKID_CW = $clog2(SKID_D + 1);
   localparam int QCW     = $clog2(PAGES + 1);

   typedef struct packed {
      logic [PAGE_W-1:0] page;
      logic [NENT_W-1:0] nent;
      logic [BX_W-1:0]   bx;
   } job_t;

   // Handshake: a beat moves on any cycle where out_valid and out_ready are
   // both high; while out_valid is high and out_ready low the beat holds.
   pmr_state_e          state_q, state_d;
   job_t                jq_q [PAGES];
   job_t                jq_d [PAGES];
   logic [PAGE_W-1:0]   jq_wr_q, jq_wr_d, jq_rd_q, jq_rd_d;
   logic [QCW-1:0]      jq_cnt_q, jq_cnt_d;
   logic [PAGE_W-1:0]   cur_page_q, cur_page_d;
   logic [NENT_W-1:0]   cur_nent_q, cur_nent_d;
   logic [BX_W-1:0]     cur_bx_q, cur_bx_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [SKID_CW-1:0]  infl_q, infl_d;
   logic [READ_LAT-1:0] pipe_v_q, pipe_v_d, pipe_l_q, pipe_l_d;
   logic                page_release_q, page_release_d;
   logic [PAGE_W-1:0]   release_pg_q, release_pg_d;
   logic                err_ovf_q, err_ovf_d, err_nent_q, err_nent_d;

   logic [SKID_CW-1:0]  skid_cnt;
   logic [RAM_WIDTH:0]  skid_dout;
   logic                skid_valid;
   logic                ret_valid, beat_pop;
   logic [SKID_CW:0]    occ;
   logic                issue, last_addr, q_push, q_pop, work_pending, nent_big;
   job_t                job_in, job_head;

   assign ret_valid = pipe_v_q[READ_LAT-1];
   assign beat_pop  = skid_valid && out_ready;

   always_comb begin
      nent_big     = nent_in > NENT_W'(RAM_DEPTH);
      job_in.page  = page_in;
      job_in.nent  = nent_big ? NENT_W'(RAM_DEPTH) : nent_in;
      job_in.bx    = bx_in;
      job_head     = jq_q[jq_rd_q];
      // Count the beat leaving this cycle so the loop sustains one per cycle
      // with only READ_LAT+1 skid slots.
      occ          = (SKID_CW+1)'(skid_cnt) + (SKID_CW+1)'(infl_q) - (SKID_CW+1)'(beat_pop);
      issue        = (state_q == ST_READ) && (occ < (SKID_CW+1)'(SKID_D));
      last_addr    = NENT_W'(rd_addr_q) == (cur_nent_q - NENT_W'(1));
      q_pop        = (state_q == ST_LOAD);
      q_push       = page_done && ((jq_cnt_q != QCW'(PAGES)) || q_pop);
      work_pending = (jq_cnt_q != '0) || page_done;

      jq_d    = jq_q;
      jq_wr_d = jq_wr_q;
      jq_rd_d = jq_rd_q;
      if (q_push) begin
         jq_d[jq_wr_q] = job_in;
         jq_wr_d = (jq_wr_q == PAGE_W'(PAGES - 1)) ? '0 : jq_wr_q + PAGE_W'(1);
      end
      if (q_pop) begin
         jq_rd_d = (jq_rd_q == PAGE_W'(PAGES - 1)) ? '0 : jq_rd_q + PAGE_W'(1);
      end
      jq_cnt_d   = jq_cnt_q + QCW'(q_push) - QCW'(q_pop);
      err_ovf_d  = err_ovf_q || (page_done && !q_push);
      err_nent_d = err_nent_q || (page_done && nent_big);

      state_d    = state_q;
      cur_page_d = cur_page_q;
      cur_nent_d = cur_nent_q;
      cur_bx_d   = cur_bx_q;
      rd_addr_d  = rd_addr_q;
      case (state_q)
         ST_IDLE: if (work_pending) state_d = ST_LOAD;
         ST_LOAD: begin
            cur_page_d = job_head.page;
            cur_nent_d = job_head.nent;
            cur_bx_d   = job_head.bx;
            rd_addr_d  = '0;
            state_d    = (job_head.nent == '0) ? ST_RELEASE : ST_READ;
         end
         ST_READ: begin
            if (issue) begin
               if (last_addr) state_d = ST_DRAIN;
               else           rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN:   if ((infl_q == '0) && (skid_cnt == '0)) state_d = ST_RELEASE;
         ST_RELEASE: state_d = work_pending ? ST_LOAD : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      page_release_d = (state_d == ST_RELEASE);
      release_pg_d   = page_release_d ? cur_page_d : '0;

      pipe_v_d[0] = issue;
      pipe_l_d[0] = issue && last_addr;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_l_d[i] = pipe_l_q[i-1];
      end
      infl_d = infl_q + SKID_CW'(issue) - SKID_CW'(ret_valid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         for (int i = 0; i < PAGES; i++) jq_q[i] <= '0;
         jq_wr_q        <= '0;
         jq_rd_q        <= '0;
         jq_cnt_q       <= '0;
         cur_page_q     <= '0;
         cur_nent_q     <= '0;
         cur_bx_q       <= '0;
         rd_addr_q      <= '0;
         infl_q         <= '0;
         pipe_v_q       <= '0;
         pipe_l_q       <= '0;
         page_release_q <= 1'b0;
         release_pg_q   <= '0;
         err_ovf_q      <= 1'b0;
         err_nent_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         jq_q           <= jq_d;
         jq_wr_q        <= jq_wr_d;
         jq_rd_q        <= jq_rd_d;
         jq_cnt_q       <= jq_cnt_d;
         cur_page_q     <= cur_page_d;
         cur_nent_q     <= cur_nent_d;
         cur_bx_q       <= cur_bx_d;
         rd_addr_q      <= rd_addr_d;
         infl_q         <= infl_d;
         pipe_v_q       <= pipe_v_d;
         pipe_l_q       <= pipe_l_d;
         page_release_q <= page_release_d;
         release_pg_q   <= release_pg_d;
         err_ovf_q      <= err_ovf_d;
         err_nent_q     <= err_nent_d;
      end
   end

   pmr_skid_fifo #(
      .W     (RAM_WIDTH + 1),
      .DEPTH (SKID_D)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (ret_valid),
      .in_data   ({pipe_l_q[READ_LAT-1], mem_doutb}),
      .out_valid (skid_valid),
      .out_ready (out_ready),
      .out_data  (skid_dout),
      .count     (skid_cnt)
   );

   assign mem_enb      = issue;
   assign mem_pageb    = cur_page_q;
   assign mem_addrb    = rd_addr_q;
   assign out_valid    = skid_valid;
   assign out_data     = skid_dout[RAM_WIDTH-1:0];
   assign out_last     = skid_valid && skid_dout[RAM_WIDTH];
   assign out_bx       = cur_bx_q;
   assign page_release = page_release_q;
   assign release_pg   = release_pg_q;
   assign busy         = (state_q != ST_IDLE) || (jq_cnt_q != '0);
   assign err_ovf      = err_ovf_q;
   assign err_nent     = err_nent_q;
   assign dbg_state    = state_q;

endmodule
